// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I core: opcodes, FSM states and the
// select/op encodings seen by both the control FSM and the datapath muxes.
package rv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpCustom = 7'b0001011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StExecC,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpDecode = 2'b10;
    localparam logic [1:0] AluOpCustom = 2'b11;

    // Successor of DECODE for a given opcode; anything unrecognised traps.
    function automatic state_e dispatch(input logic [6:0] opcode);
        case (opcode)
            OpLoad, OpStore: dispatch = StMemAdr;
            OpRtype:         dispatch = StExecR;
            OpItype:         dispatch = StExecI;
            OpCustom:        dispatch = StExecC;
            OpBranch:        dispatch = StBranch;
            OpJal:           dispatch = StJal;
            default:         dispatch = StTrap;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch outcome from funct3 and the ALU flags of the compare performed in BRANCH.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = alu_zero;
            3'b001:         taken = !alu_zero;
            3'b100, 3'b110: taken = alu_lt;
            3'b101, 3'b111: taken = !alu_lt;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute, memory
// and writeback over the shared ALU and single memory port.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   taken;

    branch_cond u_branch_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .taken    (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluOpAdd;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read   = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                state_d   = dispatch(opcode);
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                result_src = ResMemData;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR, StExecI, StExecC: begin
                alu_src_a = SrcARs1;
                alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBRs2;
                alu_op    = (state_q == StExecC) ? AluOpCustom : AluOpDecode;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_op    = AluOpBranch;
                pc_write  = taken;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                // PC takes the target computed in DECODE while the ALU forms the link value.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = StTrap;
            end
        endcase

        // Reset drops any in-flight request combinationally, not just on the next edge.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; every output is compared as one packed
// vector against hand-built per-state expectations.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       alu_lt;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;

    logic [15:0] obs;
    int          n_run;
    int          n_fail;

    // Strobes plus illegal: mem_read, mem_write, ir_write, pc_write, reg_write, retire, illegal.
    localparam logic [15:0] StrobeMask = 16'hDC03;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .retire     (retire),
        .illegal    (illegal)
    );

    assign obs = {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, retire, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ev(input logic mr, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic ret, input logic ill);
        return {mr, mw, adr, irw, pcw, rw, rs, a, b, op, ret, ill};
    endfunction

    function automatic logic [15:0] e_fetch(input logic r);
        return ev(1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_decode();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_memadr();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_memrd();
        return ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_memwb();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    endfunction
    function automatic logic [15:0] e_memwr(input logic r);
        return ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, r, 1'b0);
    endfunction
    function automatic logic [15:0] e_exec(input logic [1:0] b, input logic [1:0] op);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, b, op, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_aluwb();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    endfunction
    function automatic logic [15:0] e_branch(input logic t);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, t, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0);
    endfunction
    function automatic logic [15:0] e_jal();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [15:0] e_trap();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_run++;
            if ((obs & StrobeMask) !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_strobes cyc %0d: got %h required %h", i,
                         obs & StrobeMask, 16'h0000);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [15:0] ex [4];
        ex = '{e_fetch(1'b1), e_decode(), e_exec(2'b00, 2'b10), e_aluwb()};
        opcode    = 7'b0110011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL rtype cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_imm_custom();
        logic [6:0]  ops [2];
        logic [15:0] ex  [2][4];
        ops = '{7'b0010011, 7'b0001011};
        ex[0] = '{e_fetch(1'b1), e_decode(), e_exec(2'b01, 2'b10), e_aluwb()};
        ex[1] = '{e_fetch(1'b1), e_decode(), e_exec(2'b00, 2'b11), e_aluwb()};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                #1;
                n_run++;
                if (obs !== ex[k][i]) begin
                    n_fail++;
                    $display("FAIL imm_custom op %b cyc %0d: got %h required %h",
                             ops[k], i, obs, ex[k][i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_load_wait();
        logic        rdy [9];
        logic [15:0] ex  [9];
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ex  = '{e_fetch(1'b0), e_fetch(1'b0), e_fetch(1'b1), e_decode(), e_memadr(),
                e_memrd(), e_memrd(), e_memrd(), e_memwb()};
        opcode = 7'b0000011;
        funct3 = 3'b010;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL load_wait cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_store();
        logic [15:0] ex [4];
        ex = '{e_fetch(1'b1), e_decode(), e_memadr(), e_memwr(1'b1)};
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL store cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [6];
        logic       z  [6];
        logic       lt [6];
        logic       tk [6];
        logic [15:0] ex [3];
        f3 = '{3'b001, 3'b001, 3'b101, 3'b000, 3'b110, 3'b011};
        z  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
        lt = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
        tk = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
        opcode    = 7'b1100011;
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            funct3   = f3[k];
            alu_zero = z[k];
            alu_lt   = lt[k];
            ex = '{e_fetch(1'b1), e_decode(), e_branch(tk[k])};
            for (int i = 0; i < 3; i++) begin
                #1;
                n_run++;
                if (obs !== ex[i]) begin
                    n_fail++;
                    $display("FAIL branch f3 %b z %b lt %b cyc %0d: got %h required %h",
                             f3[k], z[k], lt[k], i, obs, ex[i]);
                end
                tick();
            end
        end
        alu_zero = 1'b0;
        alu_lt   = 1'b0;
    endtask

    task automatic test_jal();
        logic [15:0] ex [4];
        ex = '{e_fetch(1'b1), e_decode(), e_jal(), e_aluwb()};
        opcode    = 7'b1101111;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL jal cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_trap();
        logic [15:0] ex [2];
        ex = '{e_fetch(1'b1), e_decode()};
        opcode    = 7'b1111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL trap_entry cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            n_run++;
            if (obs !== e_trap()) begin
                n_fail++;
                $display("FAIL trap_hold cyc %0d: got %h required %h", i, obs, e_trap());
            end
            tick();
        end
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_run++;
        if ((obs & StrobeMask) !== 16'h0000) begin
            n_fail++;
            $display("FAIL trap_rst_strobes: got %h required %h", obs & StrobeMask, 16'h0000);
        end
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_run++;
        if (obs !== e_fetch(1'b0)) begin
            n_fail++;
            $display("FAIL trap_exit: got %h required %h", obs, e_fetch(1'b0));
        end
        tick();
    endtask

    task automatic test_reset_mid_store();
        logic        rdy [4];
        logic [15:0] ex  [4];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        ex  = '{e_fetch(1'b1), e_decode(), e_memadr(), e_memwr(1'b0)};
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            n_run++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL rst_store cyc %0d: got %h required %h", i, obs, ex[i]);
            end
            tick();
        end
        // Still waiting in MEMWR; reset with ready high must neither write nor retire.
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_run++;
        if ((obs & StrobeMask) !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_store_drop: got %h required %h", obs & StrobeMask, 16'h0000);
        end
        tick();
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_run++;
        if (obs !== e_fetch(1'b1)) begin
            n_fail++;
            $display("FAIL rst_store_fetch: got %h required %h", obs, e_fetch(1'b1));
        end
        tick();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_rtype();
        test_imm_custom();
        test_load_wait();
        test_store();
        test_branch();
        test_jal();
        test_trap();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
